fetch_unpack: RTL and testbench

- Instruction fetch stage directly upstream of the decode stage.
- Fetches 64-byte cache lines over the 64-bit system bus and splits each beat into two 32-bit instructions.
- Buffers the instructions in a FIFO and presents them one per cycle, with PC, to the decode input with a valid/ready handshake.
- Detects the all-zero end-of-program word and signals completion.

---
 rtl/fetch_unpack_if.sv | 26 ++
 rtl/fetch_unpack.sv | 125 ++++++++++++
 tb/tb_fetch_unpack.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_unpack_if.sv
// fetch_unpack_if: system-bus and decode-side handshake signals of the fetch stage
interface fetch_unpack_if #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13
);
  logic                      bus_reqcyc;
  logic [BUS_DATA_WIDTH-1:0] bus_req;
  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag;
  logic                      bus_reqack;
  logic                      bus_respcyc;
  logic [BUS_DATA_WIDTH-1:0] bus_resp;
  logic [BUS_TAG_WIDTH-1:0]  bus_resptag;
  logic                      bus_respack;
  logic [31:0]               outIns;
  logic [BUS_DATA_WIDTH-1:0] ins_pc;
  logic                      ins_valid;
  logic                      ins_ready;
  modport master (
    output bus_reqcyc, bus_req, bus_reqtag, bus_respack, outIns, ins_pc, ins_valid,
    input  bus_reqack, bus_respcyc, bus_resp, bus_resptag, ins_ready
  );
  modport slave (
    input  bus_reqcyc, bus_req, bus_reqtag, bus_respack, outIns, ins_pc, ins_valid,
    output bus_reqack, bus_respcyc, bus_resp, bus_resptag, ins_ready
  );
endinterface

// File: rtl/fetch_unpack.sv
// fetch_unpack: fetches cache lines, splits beats into instructions, queues them for decode
module fetch_unpack #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int FIFO_DEPTH     = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [BUS_DATA_WIDTH-1:0] entry_pc,
  output logic                      done,
  fetch_unpack_if.master            io
);
  localparam int W  = BUS_DATA_WIDTH;
  localparam int CW = $clog2(FIFO_DEPTH);
  localparam logic [BUS_TAG_WIDTH-1:0] READ_TAG = BUS_TAG_WIDTH'(13'h1100);
  localparam logic [CW:0] REFILL_LEVEL = (CW+1)'(FIFO_DEPTH - 16);
  typedef enum logic [2:0] {IDLE, REQ, RESP, WAIT, HALT} state_t;
  state_t        state_q, state_d;
  logic [W-1:0]  line_q, line_d;
  logic [3:0]    skip_q, skip_d;
  logic [2:0]    beat_q, beat_d;
  logic          halt_q, halt_d;
  logic [CW-1:0] wr_q, rd_q, wa1;
  logic [CW:0]   cnt_q, cnt_d;
  logic [31:0]   ins_mem [FIFO_DEPTH];
  logic [W-1:0]  pc_mem [FIFO_DEPTH];
  logic [31:0]   last_ins_q;
  logic [W-1:0]  last_pc_q;
  logic          acc, e0, e1, z0, z1, w0, w1, pop;
  logic [3:0]    s0, s1;
  logic [1:0]    npush;
  logic          unused_ok;
  assign unused_ok = &{1'b0, io.bus_resptag, entry_pc[1:0]};
  // slot eligibility, halt detection, FIFO occupancy and next state
  always_comb begin
    acc = state_q == RESP && io.bus_respcyc;
    s0 = {beat_q, 1'b0};
    s1 = {beat_q, 1'b1};
    e0 = acc && !halt_q && s0 >= skip_q;
    z0 = e0 && io.bus_resp[31:0] == 32'd0;
    w0 = e0 && !z0;
    e1 = acc && !halt_q && !z0 && s1 >= skip_q;
    z1 = e1 && io.bus_resp[63:32] == 32'd0;
    w1 = e1 && !z1;
    wa1 = wr_q + CW'(w0);
    pop = cnt_q != '0 && io.ins_ready;
    npush = {1'b0, w0} + {1'b0, w1};
    cnt_d = cnt_q + (CW+1)'(npush) - (CW+1)'(pop);
    halt_d = halt_q | z0 | z1;
    state_d = state_q;
    line_d = line_q;
    skip_d = skip_q;
    beat_d = beat_q;
    case (state_q)
      IDLE: if (start) begin
        line_d = {entry_pc[W-1:6], 6'd0};
        skip_d = entry_pc[5:2];
        state_d = REQ;
      end
      REQ: if (io.bus_reqack) begin
        beat_d = 3'd0;
        state_d = RESP;
      end
      RESP: if (io.bus_respcyc) begin
        beat_d = beat_q + 3'd1;
        if (beat_q == 3'd7) begin
          if (halt_d) state_d = HALT;
          else begin
            line_d = line_q + W'(64);
            skip_d = 4'd0;
            state_d = cnt_d <= REFILL_LEVEL ? REQ : WAIT;
          end
        end
      end
      WAIT: state_d = cnt_q <= REFILL_LEVEL ? REQ : WAIT;
      default: state_d = state_q;
    endcase
  end
  assign io.bus_reqcyc  = state_q == REQ;
  assign io.bus_req     = io.bus_reqcyc ? line_q : '0;
  assign io.bus_reqtag  = io.bus_reqcyc ? READ_TAG : '0;
  assign io.bus_respack = acc;
  assign io.ins_valid   = cnt_q != '0;
  assign io.outIns      = io.ins_valid ? ins_mem[rd_q] : last_ins_q;
  assign io.ins_pc      = io.ins_valid ? pc_mem[rd_q] : last_pc_q;
  assign done           = state_q == HALT && cnt_q == '0;
  // instruction storage; lower slot lands first when a beat yields two entries
  always_ff @(posedge clk) begin
    if (w0) begin
      ins_mem[wr_q] <= io.bus_resp[31:0];
      pc_mem[wr_q]  <= {line_q[W-1:6], s0, 2'b00};
    end
    if (w1) begin
      ins_mem[wa1] <= io.bus_resp[63:32];
      pc_mem[wa1]  <= {line_q[W-1:6], s1, 2'b00};
    end
  end
  // control state, FIFO pointers and the held output when the FIFO drains
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      line_q     <= '0;
      skip_q     <= '0;
      beat_q     <= '0;
      halt_q     <= 1'b0;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      last_ins_q <= '0;
      last_pc_q  <= '0;
    end else begin
      state_q    <= state_d;
      line_q     <= line_d;
      skip_q     <= skip_d;
      beat_q     <= beat_d;
      halt_q     <= state_q == IDLE ? 1'b0 : halt_d;
      wr_q       <= wr_q + CW'(npush);
      rd_q       <= rd_q + CW'(pop);
      cnt_q      <= cnt_d;
      last_ins_q <= io.outIns;
      last_pc_q  <= io.ins_pc;
    end
  end
endmodule

// File: tb/tb_fetch_unpack.sv
// tb_fetch_unpack: table-driven fetch scenarios against a bus model and an in-order pop checker
module tb_fetch_unpack;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0, done;
  logic [63:0] entry_pc = '0;
  always #5 clk = ~clk;
  fetch_unpack_if io ();
  fetch_unpack dut (.clk(clk), .reset(reset), .start(start), .entry_pc(entry_pc), .done(done), .io(io.master));
  typedef struct {
    logic [63:0] entry, z, z2;
    int ack, stall, n, req;
    bit lat, mid;
  } vec_t;
  vec_t tv [7];
  int n_cmp = 0, n_bad = 0;
  logic [63:0] zaddr = 64'h1, zaddr2 = 64'h1, cur = '0, exp_line = '0, exp_pc = '0;
  int ack_dly = 1, bph = 0, wcnt = 0, bidx = 0, nreq = 0, popped = 0;
  bit chk_lat = 1'b0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] word(input logic [63:0] a);
    if (a == zaddr || a == zaddr2) return 32'h0;
    if (a == 64'h1000) return 32'h00100093;
    return {a[23:0], 8'h13};
  endfunction
  initial begin
    io.bus_reqack = 1'b0;
    io.bus_respcyc = 1'b0;
    io.bus_resp = '0;
    io.bus_resptag = '0;
    forever begin
      @(posedge clk);
      #1;
      io.bus_reqack = 1'b0;
      io.bus_respcyc = 1'b0;
      if (!reset) begin
        bph = 0;
        wcnt = 0;
        continue;
      end
      if (bph == 1) begin
        if (chk_lat && bidx == 0) chk("valid_before_beat", io.ins_valid, 1'b0);
        if (chk_lat && bidx == 1) begin
          chk("valid_latency", io.ins_valid, 1'b1);
          chk_lat = 1'b0;
        end
        if (bidx == 8) bph = 0;
        else begin
          io.bus_respcyc = 1'b1;
          io.bus_resp = {word(cur + 64'(8 * bidx + 4)), word(cur + 64'(8 * bidx))};
          bidx++;
          #1 chk("respack", io.bus_respack, 1'b1);
        end
      end
      if (bph == 0 && io.bus_reqcyc) begin
        chk("req_addr", io.bus_req, exp_line);
        chk("req_tag", 64'(io.bus_reqtag), 64'h1100);
        wcnt++;
        if (wcnt >= ack_dly) begin
          io.bus_reqack = 1'b1;
          cur = io.bus_req;
          nreq++;
          exp_line += 64;
          wcnt = 0;
          bidx = 0;
          bph = 1;
        end
      end
    end
  end
  always @(negedge clk) if (reset && io.ins_valid && io.ins_ready) begin
    chk("pop_pc", io.ins_pc, exp_pc);
    chk("pop_ins", 64'(io.outIns), 64'(word(exp_pc)));
    exp_pc += 4;
    popped++;
  end
  task automatic run_case(input vec_t v);
    int cyc;
    reset = 1'b0;
    start = 1'b0;
    io.ins_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_reqcyc", io.bus_reqcyc, 1'b0);
    chk("rst_req", io.bus_req, 64'h0);
    chk("rst_reqtag", 64'(io.bus_reqtag), 64'h0);
    chk("rst_respack", io.bus_respack, 1'b0);
    chk("rst_outins", 64'(io.outIns), 64'h0);
    chk("rst_inspc", io.ins_pc, 64'h0);
    chk("rst_valid", io.ins_valid, 1'b0);
    chk("rst_done", done, 1'b0);
    zaddr = v.z;
    zaddr2 = v.z2;
    ack_dly = v.ack;
    chk_lat = v.lat;
    exp_line = v.entry & ~64'h3F;
    exp_pc = v.entry;
    popped = 0;
    nreq = 0;
    reset = 1'b1;
    @(posedge clk);
    #1 start = 1'b1;
    entry_pc = v.entry;
    @(posedge clk);
    #1 start = 1'b0;
    entry_pc = 64'hDEAD_BEEF_0000_0000;
    if (v.stall > 0) begin
      repeat (v.stall) @(posedge clk);
      #1;
      chk("stall_reqs", 64'(nreq), 64'd2);
      chk("stall_pops", 64'(popped), 64'd0);
    end
    io.ins_ready = 1'b1;
    if (v.mid) begin
      repeat (12) @(posedge clk);
      #1 start = 1'b1;
      entry_pc = 64'h9000;
      @(posedge clk);
      #1 start = 1'b0;
    end
    cyc = 0;
    while (!(done && popped >= v.n) && cyc < 3000) begin
      @(posedge clk);
      #1 cyc++;
    end
    chk("finish_in_time", 64'(cyc < 3000), 64'd1);
    repeat (10) @(posedge clk);
    #1;
    chk("pops", 64'(popped), 64'(v.n));
    chk("reqs", 64'(nreq), 64'(v.req));
    chk("done", done, 1'b1);
    chk("idle_valid", io.ins_valid, 1'b0);
    chk("held_pc", io.ins_pc, v.entry + 64'(4 * (v.n - 1)));
  endtask
  initial begin
    int cyc;
    vec_t rv;
    io.ins_ready = 1'b0;
    tv[0] = '{64'h1000, 64'h1040, 64'h1,    2, 0,  16, 2, 1'b1, 1'b0};
    tv[1] = '{64'h1008, 64'h1080, 64'h1,    1, 0,  30, 3, 1'b0, 1'b1};
    tv[2] = '{64'h1000, 64'h1018, 64'h1,    1, 0,   6, 1, 1'b1, 1'b0};
    tv[3] = '{64'h2000, 64'h2100, 64'h1,    1, 40, 64, 5, 1'b1, 1'b0};
    tv[4] = '{64'h303C, 64'h3040, 64'h1,    3, 0,   1, 2, 1'b0, 1'b0};
    tv[5] = '{64'h4004, 64'h4010, 64'h4000, 1, 0,   3, 1, 1'b0, 1'b0};
    tv[6] = '{64'h5000, 64'h501C, 64'h1,    1, 0,   7, 1, 1'b1, 1'b0};
    for (int i = 0; i < 7; i++) run_case(tv[i]);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 zaddr = 64'h6040;
    zaddr2 = 64'h1;
    ack_dly = 1;
    chk_lat = 1'b0;
    exp_line = 64'h6000;
    exp_pc = 64'h6000;
    popped = 0;
    nreq = 0;
    io.ins_ready = 1'b1;
    reset = 1'b1;
    @(posedge clk);
    #1 start = 1'b1;
    entry_pc = 64'h6000;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    while (!(bph == 1 && bidx == 5) && cyc < 200) begin
      @(posedge clk);
      #2 cyc++;
    end
    chk("reach_beat4", 64'(cyc < 200), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_reqcyc", io.bus_reqcyc, 1'b0);
    chk("midrst_respack", io.bus_respack, 1'b0);
    chk("midrst_valid", io.ins_valid, 1'b0);
    rv = '{64'h2000, 64'h2020, 64'h1, 1, 0, 8, 1, 1'b1, 1'b0};
    run_case(rv);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
